// File: rtl/skid_fifo.sv
// skid_fifo: registered-output FIFO with AXI-Stream style handshakes on both ports.
// Define SKID_FIFO_LEVEL_EN to expose the occupancy count on level; otherwise level is tied to 0.
module skid_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] cnt, cnt_nxt;
  logic push, pop, head_in;
  always_comb begin
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    rd_nxt  = rd_ptr + AW'(pop);
    cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);
    head_in = push && cnt_nxt == (AW+1)'(1);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_last, in_data};
  // The head register is refilled from the bypass when the pushed beat becomes the only entry.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= cnt_nxt < (AW+1)'(DEPTH);
      out_valid <= cnt_nxt != '0;
      if (head_in) {out_last, out_data} <= {in_last, in_data};
      else if (pop && cnt_nxt != '0) {out_last, out_data} <= mem[rd_nxt];
    end
`ifdef SKID_FIFO_LEVEL_EN
  assign level = cnt;
`else
  assign level = '0;
`endif
endmodule

// File: doc/skid_fifo.md
SKID_FIFO -- requirements
Module: skid_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of in_data/out_data in bits (multiple of 8, >= 8).
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-006 SHALL have port in_last  input  1  upstream packet-end marker, stored alongside in_data.
REQ-007 SHALL have port in_valid  input  1  upstream beat offered.
REQ-008 SHALL have port in_ready  output  1  entry free; beat accepted when in_valid && in_ready.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  payload at head of queue.
REQ-010 SHALL have port out_last  output  1  marker at head of queue.
REQ-011 SHALL have port out_valid  output  1  queue non-empty.
REQ-012 SHALL have port out_ready  input  1  downstream accepts; beat removed when out_valid && out_ready.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  occupancy count (see Configuration).

Function
REQ-014 SHALL store accepted beats in order and present them on out_data/out_last first-in first-out, with no loss, duplication or reordering.
REQ-015 SHALL drive in_ready, out_valid, out_data, out_last and level from registers only; no combinational path from any input to any output.
REQ-016 SHALL assert in_ready iff occupancy < DEPTH, evaluated from state at the start of the cycle; a pop in a full cycle does not raise in_ready that cycle.
REQ-017 SHALL assert out_valid iff occupancy > 0; a beat pushed into an empty queue appears on out_valid exactly 1 cycle after acceptance (no same-cycle pass-through).
REQ-018 SHALL, on simultaneous push and pop, leave occupancy unchanged and update both pointers.
REQ-019 SHALL keep out_data/out_last stable while out_valid && !out_ready (AXI-Stream source stability).
REQ-020 SHALL never deassert out_valid without a completed pop.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; full/empty distinguished by occupancy counter of width $clog2(DEPTH)+1.
REQ-022 SHALL ignore in_data/in_last when in_valid is low or in_ready is low.
REQ-023 SHALL sustain one beat per cycle throughput when 0 < occupancy < DEPTH and both sides handshake every cycle.

Reset
REQ-024 SHALL, while resetn is low, immediately force in_ready=0, out_valid=0, level=0, pointers=0; out_data/out_last=0.
REQ-025 SHALL discard all stored beats on reset, including reset asserted mid-transfer; no beat present before reset appears after it.
REQ-026 SHALL raise in_ready on the first rising clk edge after resetn deasserts (synchronous release of internal state).

Configuration
REQ-027 SHALL, when macro SKID_FIFO_LEVEL_EN is defined, drive level with current occupancy (0..DEPTH), registered, updated same edge as pointers.
REQ-028 SHALL, when SKID_FIFO_LEVEL_EN is undefined, tie level to 0 and synthesise no extra logic beyond the occupancy counter needed for full/empty.

Verification
REQ-029 Bench: DEPTH=4, out_ready=0, push 0x11,0x22,0x33,0x44 back-to-back -> in_ready low the cycle after 4th accept, level=4 (LEVEL_EN), out_data=0x11 held.
REQ-030 Bench: from full, out_ready=1 one cycle with in_valid=1 -> 0x11 popped, no push that cycle, in_ready=1 next cycle, level=3.
REQ-031 Bench: empty queue, push 0xA5 with in_last=1 at cycle N -> out_valid=1, out_data=0xA5, out_last=1 at cycle N+1, not N.
REQ-032 Bench: in_valid=1, out_ready=1 continuous for 16 cycles, data 0..15 -> out_data sequence 0..15, pointers wrap 4 times, one beat per cycle after first.
REQ-033 Bench: 2 beats stored, resetn pulsed low between edges -> out_valid, in_ready, level drop to 0 immediately; after release, stored beats never appear.
REQ-034 Bench: formal — AXI-Stream master/slave monitors on both ports, rx_count - tx_count equals occupancy, and no out_valid before any in_valid, proven for DATA_WIDTH=8, DEPTH=4.
